// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Single-port frame-buffer arbiter and 1bpp pixel serialiser for the 256x240
// presets. Video fetches own every eighth pixel of a visible line and always
// win that cycle. A CPU access takes three cycles: grant, read-back, ack. Each
// fetched byte is shifted out MSB first, one pixel per clock. A pulse is also
// raised at the start of vblank.
//
// Ports
//   clk, reset        pixel clock; synchronous active-high reset
//   hpos, vpos        beam position from the sync generator
//   display_on        beam inside the visible area
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_ack
//   cpu_ack           one-cycle completion pulse (grant + 2)
//   cpu_rdata         read data, valid with cpu_ack and held afterwards
//   ram_addr/we/wdata RAM command, combinational from the current owner
//   ram_rdata         RAM read data, one-cycle latency
//   pixel             serialised pixel, 2 cycles behind hpos
//   pixel_valid       display_on delayed by 2 cycles
//   frame_irq         one-cycle pulse after the line V_DISPLAY / hpos 0 cycle
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int V_DISPLAY = 240,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              display_on,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              frame_irq
);

  // Pixel lag behind hpos: one cycle of RAM latency plus the load cycle.
  localparam int PIX_LAG = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_ACK
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                cpu_grant;
  logic                video_slot;
  logic [ADDR_W-1:0]   video_addr;

  // Remembers whether the granted access was a write, so the READ state
  // knows whether ram_rdata is meaningful for the CPU.
  logic                write_reg;
  logic                cpu_ack_reg;
  logic [7:0]          cpu_rdata_reg;

  logic                slot_d1_reg;
  logic [7:0]          shreg_reg;
  logic [7:0]          shreg_next;
  logic [7:0]          shift_in;
  logic [PIX_LAG-1:0]  disp_pipe_reg;
  logic [PIX_LAG:0]    disp_chain;
  logic                frame_irq_reg;

  // ---------------------------------------------------------------------------
  // Slot decode. Slots are 1 in 8 cycles, so two are never adjacent and a CPU
  // request blocked by one is granted on the very next cycle.
  // ---------------------------------------------------------------------------
  assign video_slot = display_on && (hpos[2:0] == 3'd0);
  assign video_addr = ADDR_W'({vpos[7:0], hpos[7:3]});

  // ---------------------------------------------------------------------------
  // CPU access FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cpu_grant  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_req && !video_slot) begin
          cpu_grant  = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: state_next = ST_ACK;
      // A request still high here is ignored; it is seen again in IDLE.
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      write_reg     <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      cpu_rdata_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      if (cpu_grant) begin
        write_reg <= cpu_we;
      end
      cpu_ack_reg <= (state_reg == ST_READ);
      if ((state_reg == ST_READ) && !write_reg) begin
        cpu_rdata_reg <= ram_rdata;
      end
    end
  end

  assign cpu_ack   = cpu_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;

  // ---------------------------------------------------------------------------
  // RAM command mux. Video has priority; an idle bus simply mirrors the CPU
  // inputs with the write strobe low. The strobe is also gated by reset so a
  // write granted in the cycle reset rises never reaches the RAM.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    if (video_slot) begin
      ram_addr = video_addr;
    end else if (cpu_grant) begin
      ram_we = cpu_we && !reset;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel serialiser. The byte fetched in a slot arrives one cycle later and is
  // loaded then; every other cycle shifts left with a zero fill, so after the
  // last slot of a line the register drains to 0 by itself.
  // ---------------------------------------------------------------------------
  assign shift_in = {shreg_reg[6:0], 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shreg_bit
      assign shreg_next[gi] = slot_d1_reg ? ram_rdata[gi] : shift_in[gi];
    end
  endgenerate

  // display_on shifts through PIX_LAG stages so pixel_valid lines up with
  // the serialised data.
  assign disp_chain = {disp_pipe_reg, display_on};

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_d1_reg   <= 1'b0;
      shreg_reg     <= 8'h00;
      disp_pipe_reg <= '0;
      frame_irq_reg <= 1'b0;
    end else begin
      slot_d1_reg   <= video_slot;
      shreg_reg     <= shreg_next;
      disp_pipe_reg <= disp_chain[PIX_LAG-1:0];
      frame_irq_reg <= (vpos == 9'(V_DISPLAY)) && (hpos == 9'd0);
    end
  end

  assign pixel_valid = disp_pipe_reg[PIX_LAG-1];
  assign pixel       = shreg_reg[7] & pixel_valid;
  assign frame_irq   = frame_irq_reg;

endmodule
